// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the IFU/LSU memory arbiter
package mem_arb_pkg;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int MASK_W          = DATA_W / 8;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TO_CNT_W        = $clog2(TIMEOUT_DEFAULT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_IFU, WAIT_LSU} arb_state_e;
    typedef enum logic {REQ_IFU, REQ_LSU} req_id_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-port signals of the arbiter (slave = arbiter side)
interface mem_arbiter_if;
    import mem_arb_pkg::*;
    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_done;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_err;
    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_done;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask, mem_resp, mem_rdata,
        output ifu_done, ifu_rdata, ifu_err, lsu_done, lsu_rdata, lsu_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req, ifu_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask, mem_resp, mem_rdata,
        input  ifu_done, ifu_rdata, ifu_err, lsu_done, lsu_rdata, lsu_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: one-entry pending request buffer with pass-through view and overflow-ignore
module mem_arb_slot
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req,
    input  mem_req_t req_data,
    input  logic     busy,
    input  logic     grant,
    output logic     eff_valid,
    output mem_req_t eff_data
);
    logic     valid_q, valid_d, load;
    mem_req_t data_q, data_d;

    assign load      = req && !valid_q && !busy;
    assign eff_valid = valid_q || load;
    assign eff_data  = valid_q ? data_q : req_data;

    // a request loads only an empty slot; a grant empties it, even when passed straight through
    always_comb begin
        valid_d = (valid_q || load) && !grant;
        data_d  = load ? req_data : data_q;
    end

    // slot registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IFU/LSU requests onto one memory port; MEM_ARB_TIMEOUT_EN adds a response timeout
module mem_arbiter
    import mem_arb_pkg::*;
`ifdef MEM_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)
`endif
(
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    req_id_e           win;
    mem_req_t          ifu_in, lsu_in, ifu_eff, lsu_eff, pay_q, pay_d;
    logic              ifu_v, lsu_v, ifu_grant, lsu_grant, ifu_busy, lsu_busy;
    logic              issue, resp, tmo, fin;
    logic              mem_req_q, mem_req_d, ifu_done_q, ifu_done_d, lsu_done_q, lsu_done_d;
    logic [DATA_W-1:0] rdata_v, ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

    assign ifu_in   = '{we: 1'b0, addr: bus.ifu_addr, wdata: '0, wmask: '0};
    assign lsu_in   = '{we: bus.lsu_we, addr: bus.lsu_addr, wdata: bus.lsu_wdata, wmask: bus.lsu_wmask};
    assign resp     = state_q != IDLE && bus.mem_resp;
    assign fin      = resp || tmo;
    assign ifu_busy = state_q == WAIT_IFU && !fin;
    assign lsu_busy = state_q == WAIT_LSU && !fin;

    mem_arb_slot u_ifu_slot (
        .clk(clk), .rst(rst), .req(bus.ifu_req), .req_data(ifu_in), .busy(ifu_busy),
        .grant(ifu_grant), .eff_valid(ifu_v), .eff_data(ifu_eff)
    );

    mem_arb_slot u_lsu_slot (
        .clk(clk), .rst(rst), .req(bus.lsu_req), .req_data(lsu_in), .busy(lsu_busy),
        .grant(lsu_grant), .eff_valid(lsu_v), .eff_data(lsu_eff)
    );

    // fixed LSU priority in IDLE; completion routes read data back to the owner of the transaction
    always_comb begin
        win         = lsu_v ? REQ_LSU : REQ_IFU;
        issue       = state_q == IDLE && (lsu_v || ifu_v);
        lsu_grant   = issue && win == REQ_LSU;
        ifu_grant   = issue && win == REQ_IFU;
        state_d     = issue ? (lsu_grant ? WAIT_LSU : WAIT_IFU) : fin ? IDLE : state_q;
        mem_req_d   = issue;
        pay_d       = issue ? (lsu_grant ? lsu_eff : ifu_eff) : pay_q;
        ifu_done_d  = fin && state_q == WAIT_IFU;
        lsu_done_d  = fin && state_q == WAIT_LSU;
        rdata_v     = resp && !pay_q.we ? bus.mem_rdata : '0;
        ifu_rdata_d = ifu_done_d ? rdata_v : ifu_rdata_q;
        lsu_rdata_d = lsu_done_d ? rdata_v : lsu_rdata_q;
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            pay_q       <= '0;
            ifu_done_q  <= 1'b0;
            lsu_done_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            pay_q       <= pay_d;
            ifu_done_q  <= ifu_done_d;
            lsu_done_q  <= lsu_done_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;

    assign tmo = state_q != IDLE && !bus.mem_resp && cnt_q == TO_CNT_W'(TIMEOUT_CYCLES);

    // wait counter restarts with each issued request and runs while waiting; err marks a timed-out completion
    always_comb begin
        cnt_d     = issue ? '0 : state_q != IDLE ? cnt_q + TO_CNT_W'(1) : cnt_q;
        ifu_err_d = ifu_done_d ? tmo : ifu_err_q;
        lsu_err_d = lsu_done_d ? tmo : lsu_err_q;
    end

    // timeout registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            ifu_err_q <= 1'b0;
            lsu_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ifu_err_q <= ifu_err_d;
            lsu_err_q <= lsu_err_d;
        end
    end

    assign bus.ifu_err = ifu_err_q;
    assign bus.lsu_err = lsu_err_q;
`else
    assign tmo         = 1'b0;
    assign bus.ifu_err = 1'b0;
    assign bus.lsu_err = 1'b0;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = pay_q.we;
    assign bus.mem_addr  = pay_q.addr;
    assign bus.mem_wdata = pay_q.wdata;
    assign bus.mem_wmask = pay_q.wmask;
    assign bus.ifu_done  = ifu_done_q;
    assign bus.ifu_rdata = ifu_rdata_q;
    assign bus.lsu_done  = lsu_done_q;
    assign bus.lsu_rdata = lsu_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;

    mem_arbiter_if bus();

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_req = 0; bus.ifu_addr = '0;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_resp = 0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [161:0] outs;
        clear_inputs();
        bus.ifu_req = 1; bus.lsu_req = 1; bus.mem_resp = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        rst = 0;
        repeat (3) tick();
        outs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.ifu_done,
                bus.ifu_rdata, bus.ifu_err, bus.lsu_done, bus.lsu_rdata, bus.lsu_err};
        total++; if (outs !== '0) $display("FAIL reset_outputs got %h exp 0", outs); else pass_cnt++;
        clear_inputs();
        rst = 1;
        tick(); tick();
        total++; if ({bus.mem_req, bus.ifu_done, bus.lsu_done} !== 3'b000)
            $display("FAIL reset_no_issue got %b exp 000", {bus.mem_req, bus.ifu_done, bus.lsu_done}); else pass_cnt++;
    endtask

    task automatic test_ifu_fetch();
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0000;
        tick();
        bus.ifu_req = 0;
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h8000_0000})
            $display("FAIL fetch_issue got %b/%b/%h exp 1/0/80000000", bus.mem_req, bus.mem_we, bus.mem_addr); else pass_cnt++;
        tick();
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b0, 32'h8000_0000})
            $display("FAIL fetch_pulse_hold got %b/%h exp 0/80000000", bus.mem_req, bus.mem_addr); else pass_cnt++;
        tick(); tick();
        bus.mem_resp = 1; bus.mem_rdata = 32'h0010_0073;
        tick();
        bus.mem_resp = 0; bus.mem_rdata = '0;
        total++; if ({bus.ifu_done, bus.ifu_rdata, bus.ifu_err, bus.lsu_done} !== {1'b1, 32'h0010_0073, 2'b00})
            $display("FAIL fetch_done got %b/%h/%b exp 1/00100073/0", bus.ifu_done, bus.ifu_rdata, bus.ifu_err); else pass_cnt++;
        tick();
        total++; if ({bus.ifu_done, bus.ifu_rdata} !== {1'b0, 32'h0010_0073})
            $display("FAIL fetch_done_hold got %b/%h exp 0/00100073", bus.ifu_done, bus.ifu_rdata); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0010;
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h8000_1000;
        tick();
        bus.ifu_req = 0; bus.lsu_req = 0;
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h8000_1000})
            $display("FAIL simul_lsu_first got %b/%h exp 1/80001000", bus.mem_req, bus.mem_addr); else pass_cnt++;
        tick();
        bus.mem_resp = 1; bus.mem_rdata = 32'hA5A5_0001;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.lsu_done, bus.lsu_rdata, bus.mem_req} !== {1'b1, 32'hA5A5_0001, 1'b0})
            $display("FAIL simul_lsu_done got %b/%h/%b exp 1/a5a50001/0", bus.lsu_done, bus.lsu_rdata, bus.mem_req); else pass_cnt++;
        tick();
        total++; if ({bus.mem_req, bus.mem_addr, bus.lsu_done} !== {1'b1, 32'h8000_0010, 1'b0})
            $display("FAIL simul_ifu_next got %b/%h exp 1/80000010", bus.mem_req, bus.mem_addr); else pass_cnt++;
        tick();
        bus.mem_resp = 1; bus.mem_rdata = 32'hA5A5_0002;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.ifu_done, bus.ifu_rdata} !== {1'b1, 32'hA5A5_0002})
            $display("FAIL simul_ifu_done got %b/%h exp 1/a5a50002", bus.ifu_done, bus.ifu_rdata); else pass_cnt++;
        tick();
    endtask

    task automatic test_store();
        bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_addr = 32'h8000_2000; bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'hF;
        tick();
        clear_inputs();
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== {2'b11, 32'h8000_2000, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL store_issue got %b/%b/%h/%h/%h", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask); else pass_cnt++;
        tick(); tick();
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== {2'b01, 32'h8000_2000, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL store_hold got %b/%b/%h/%h/%h", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask); else pass_cnt++;
        bus.mem_resp = 1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.lsu_done, bus.lsu_rdata, bus.lsu_err} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL store_done got %b/%h/%b exp 1/00000000/0", bus.lsu_done, bus.lsu_rdata, bus.lsu_err); else pass_cnt++;
        tick();
    endtask

    task automatic test_req_during_resp();
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h8000_5000;
        tick();
        bus.lsu_req = 0;
        tick();
        bus.mem_resp = 1; bus.mem_rdata = 32'h1111_2222;
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0040;
        tick();
        bus.mem_resp = 0; bus.ifu_req = 0;
        total++; if ({bus.lsu_done, bus.lsu_rdata, bus.mem_req} !== {1'b1, 32'h1111_2222, 1'b0})
            $display("FAIL rdr_lsu_done got %b/%h/%b exp 1/11112222/0", bus.lsu_done, bus.lsu_rdata, bus.mem_req); else pass_cnt++;
        tick();
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h8000_0040})
            $display("FAIL rdr_ifu_issue got %b/%h exp 1/80000040", bus.mem_req, bus.mem_addr); else pass_cnt++;
        tick();
        bus.mem_resp = 1; bus.mem_rdata = 32'h3333_4444;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.ifu_done, bus.ifu_rdata} !== {1'b1, 32'h3333_4444})
            $display("FAIL rdr_ifu_done got %b/%h exp 1/33334444", bus.ifu_done, bus.ifu_rdata); else pass_cnt++;
        tick();
    endtask

    task automatic test_overflow();
        logic bad;
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h8000_4000;
        tick();
        bus.lsu_req = 0; bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0C00;
        tick();
        bus.ifu_addr = 32'h8000_0D00;
        tick();
        bus.ifu_req = 0; bus.mem_resp = 1; bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.lsu_done, bus.lsu_rdata} !== {1'b1, 32'hCAFE_F00D})
            $display("FAIL ovf_lsu_done got %b/%h exp 1/cafef00d", bus.lsu_done, bus.lsu_rdata); else pass_cnt++;
        tick();
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h8000_0C00})
            $display("FAIL ovf_first_kept got %b/%h exp 1/80000c00", bus.mem_req, bus.mem_addr); else pass_cnt++;
        tick();
        bus.mem_resp = 1; bus.mem_rdata = 32'h0BAD_CAFE;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.ifu_done, bus.ifu_rdata} !== {1'b1, 32'h0BAD_CAFE})
            $display("FAIL ovf_ifu_done got %b/%h exp 1/0badcafe", bus.ifu_done, bus.ifu_rdata); else pass_cnt++;
        bad = 0;
        repeat (4) begin tick(); if (bus.mem_req !== 1'b0) bad = 1; end
        total++; if (bad !== 1'b0) $display("FAIL ovf_second_dropped got %b exp 0", bad); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic bad;
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h8000_3000;
        tick();
        bus.lsu_req = 0;
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h8000_3000})
            $display("FAIL to_issue got %b/%h exp 1/80003000", bus.mem_req, bus.mem_addr); else pass_cnt++;
`ifdef MEM_ARB_TIMEOUT_EN
        bad = 0;
        repeat (4) begin tick(); if (bus.lsu_done !== 1'b0) bad = 1; end
        total++; if (bad !== 1'b0) $display("FAIL to_early_done got %b exp 0", bad); else pass_cnt++;
        tick();
        total++; if ({bus.lsu_done, bus.lsu_err, bus.lsu_rdata} !== {2'b11, 32'h0})
            $display("FAIL to_done got %b/%b/%h exp 1/1/00000000", bus.lsu_done, bus.lsu_err, bus.lsu_rdata); else pass_cnt++;
        bus.mem_resp = 1; bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.lsu_done, bus.ifu_done, bus.mem_req, bus.lsu_err, bus.lsu_rdata} !== {4'b0001, 32'h0})
            $display("FAIL to_late_resp got %b/%b/%b/%b/%h exp 0/0/0/1/0", bus.lsu_done, bus.ifu_done, bus.mem_req, bus.lsu_err, bus.lsu_rdata); else pass_cnt++;
        tick();
`else
        bad = 0;
        repeat (300) begin tick(); if (bus.lsu_done !== 1'b0 || bus.mem_req !== 1'b0) bad = 1; end
        total++; if (bad !== 1'b0) $display("FAIL wait_forever got %b exp 0", bad); else pass_cnt++;
        bus.mem_resp = 1; bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_resp = 0;
        total++; if ({bus.lsu_done, bus.lsu_err, bus.lsu_rdata} !== {2'b10, 32'h7777_7777})
            $display("FAIL wait_done got %b/%b/%h exp 1/0/77777777", bus.lsu_done, bus.lsu_err, bus.lsu_rdata); else pass_cnt++;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        logic [161:0] outs;
        logic bad;
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0100;
        tick();
        bus.ifu_req = 0; bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h8000_0200;
        tick();
        bus.lsu_req = 0; rst = 0;
        tick();
        rst = 1;
        outs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.ifu_done,
                bus.ifu_rdata, bus.ifu_err, bus.lsu_done, bus.lsu_rdata, bus.lsu_err};
        total++; if (outs !== '0) $display("FAIL midrst_outputs got %h exp 0", outs); else pass_cnt++;
        bus.mem_resp = 1; bus.mem_rdata = 32'h5555_AAAA;
        tick();
        bus.mem_resp = 0;
        bad = 0;
        repeat (5) begin if (bus.ifu_done !== 1'b0 || bus.lsu_done !== 1'b0 || bus.mem_req !== 1'b0) bad = 1; tick(); end
        total++; if (bad !== 1'b0) $display("FAIL midrst_dropped got %b exp 0", bad); else pass_cnt++;
    endtask

    task automatic test_random();
        mem_req_t    pend_i[$], pend_l[$], fl;
        int          owner = 0;
        int          wait_c = 0;
        logic        exp_req = 0, exp_idone = 0, exp_ldone = 0;
        logic [31:0] exp_ir = '0, exp_lr = '0;
        clear_inputs();
        fl = '0;
        for (int c = 0; c < 600; c++) begin
            total++; if ({bus.mem_req, bus.ifu_done, bus.lsu_done} !== {exp_req, exp_idone, exp_ldone})
                $display("FAIL rnd_pulses c=%0d got %b exp %b", c, {bus.mem_req, bus.ifu_done, bus.lsu_done}, {exp_req, exp_idone, exp_ldone}); else pass_cnt++;
            total++; if ({bus.ifu_rdata, bus.lsu_rdata} !== {exp_ir, exp_lr})
                $display("FAIL rnd_rdata c=%0d got %h/%h exp %h/%h", c, bus.ifu_rdata, bus.lsu_rdata, exp_ir, exp_lr); else pass_cnt++;
            total++; if ({bus.ifu_err, bus.lsu_err} !== 2'b00)
                $display("FAIL rnd_err c=%0d got %b exp 00", c, {bus.ifu_err, bus.lsu_err}); else pass_cnt++;
            if (owner != 0) begin
                total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== fl)
                    $display("FAIL rnd_payload c=%0d got %h exp %h", c, {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask}, fl); else pass_cnt++;
            end
            bus.ifu_req   = pend_i.size() == 0 && owner != 1 && $urandom_range(0, 2) == 0;
            bus.ifu_addr  = $urandom;
            bus.lsu_req   = pend_l.size() == 0 && owner != 2 && $urandom_range(0, 2) == 0;
            bus.lsu_we    = 1'($urandom_range(0, 1));
            bus.lsu_addr  = $urandom;
            bus.lsu_wdata = $urandom;
            bus.lsu_wmask = 4'($urandom_range(0, 15));
            bus.mem_resp  = owner != 0 ? wait_c == 0 : $urandom_range(0, 7) == 0;
            bus.mem_rdata = $urandom;
            exp_req = 0; exp_idone = 0; exp_ldone = 0;
            if (bus.ifu_req) pend_i.push_back('{we: 1'b0, addr: bus.ifu_addr, wdata: '0, wmask: '0});
            if (bus.lsu_req) pend_l.push_back('{we: bus.lsu_we, addr: bus.lsu_addr, wdata: bus.lsu_wdata, wmask: bus.lsu_wmask});
            if (owner == 0) begin
                if (pend_l.size() != 0) begin fl = pend_l.pop_front(); owner = 2; end
                else if (pend_i.size() != 0) begin fl = pend_i.pop_front(); owner = 1; end
                if (owner != 0) begin exp_req = 1; wait_c = $urandom_range(1, 3); end
            end else if (bus.mem_resp) begin
                if (owner == 1) begin exp_idone = 1; exp_ir = bus.mem_rdata; end
                else begin exp_ldone = 1; exp_lr = fl.we ? 32'h0 : bus.mem_rdata; end
                owner = 0;
            end else wait_c--;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_simultaneous();
        test_store();
        test_req_during_resp();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between IFU instruction fetch (read-only) and LSU data access (read/write) in the multicycle core.
- Accepts single-cycle request pulses, buffers one pending request per requester, and serialises them onto the memory port.
- Routes each response back to the requester that issued it. Only one memory transaction is outstanding at any time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
TIMEOUT_CYCLES, 255, cycles waited for mem_resp before error (only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
ifu_req  in  1  fetch request pulse
ifu_addr  in  ADDR_W  fetch address, sampled with ifu_req
ifu_done  out  1  fetch completion pulse
ifu_rdata  out  DATA_W  fetched word, valid with ifu_done
ifu_err  out  1  error flag, valid with ifu_done
lsu_req  in  1  data request pulse
lsu_we  in  1  1=store, 0=load
lsu_addr  in  ADDR_W  data address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  byte mask
lsu_done  out  1  data completion pulse
lsu_rdata  out  DATA_W  load data, valid with lsu_done (0 for stores)
lsu_err  out  1  error flag, valid with lsu_done
mem_req  out  1  memory request pulse
mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  payload, held stable from mem_req until mem_resp
mem_resp  in  1  memory response pulse
mem_rdata  in  DATA_W  read data, valid with mem_resp

Behaviour:
- Reset (rst==0): state IDLE. Both pending slots cleared. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ifu_done, ifu_rdata, ifu_err, lsu_done, lsu_rdata, lsu_err.
- Reset mid-transaction: the in-flight request and any pending requests are dropped with no done pulse. A mem_resp arriving in IDLE is ignored.
- Pending slots: a req pulse latches its payload into that requester's slot.
  - A req that arrives while the requester's slot is full, or while its own transaction is in flight, is a protocol violation: it is ignored and the first request is kept.
- States:
  - IDLE: if any slot is full, issue a request. LSU has fixed priority over IFU. Copy the winning slot to the mem_* payload, pulse mem_req for 1 cycle, clear the slot, and go to WAIT_LSU or WAIT_IFU.
  - A req seen in IDLE with an empty slot is granted in the next cycle (pass through the slot).
  - WAIT_x: hold the payload and wait for mem_resp. On mem_resp: the next cycle pulses x_done for 1 cycle, x_rdata is registered from mem_rdata (LSU store: 0), x_err=0, and the state returns to IDLE.
- Latency, no contention: req at cycle T gives mem_req at T+1. mem_resp at T+k gives done at T+k+1. The earliest next mem_req is at T+k+2.
- Simultaneous events:
  - req from both in the same cycle: both latch; LSU is issued first.
  - req in the same cycle as mem_resp: the req latches into its slot and is not lost.
- done/rdata/err hold their values until the next done pulse; only the done pulse is single-cycle.
- mem_resp in IDLE is ignored.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined: an 8-bit (clog2(TIMEOUT_CYCLES+1)) counter clears on mem_req and increments in WAIT_x. If it reaches TIMEOUT_CYCLES without mem_resp, the next cycle pulses x_done with x_err=1 and x_rdata=0, and the state returns to IDLE. A mem_resp that arrives later in IDLE is ignored.
- Undefined: no counter. WAIT_x waits indefinitely, and ifu_err/lsu_err are constant 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, WAIT_IFU, WAIT_LSU}
  - requester id enum {REQ_IFU, REQ_LSU}
  - struct mem_req_t {we, addr, wdata, wmask}
  - constant for the timeout counter width
- Sub-module mem_arb_slot: single-entry pending buffer (valid + mem_req_t), with load/clear and overflow-ignore. Instantiated once per requester; IFU ties we=0, wdata=0, wmask=0.

Test Plan:
- IFU fetch 0x80000000, mem_resp 3 cycles after mem_req with rdata 0x00100073 -> mem_req at T+1, ifu_done at T+5, ifu_rdata=0x00100073, ifu_err=0.
- ifu_req and lsu_req (load 0x80001000) in the same cycle -> LSU address issued first. IFU mem_req follows 1 cycle after lsu_done, and both done pulses occur.
- LSU store addr 0x80002000, wdata 0xDEADBEEF, wmask 0xF -> mem_we=1 with that payload held until mem_resp, lsu_done with lsu_rdata=0.
- ifu_req in the same cycle as mem_resp of an LSU load -> the IFU request is not lost and issues after lsu_done.
- rst=0 while in WAIT_IFU, then mem_resp after reset -> no ifu_done, all outputs 0, state IDLE.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no mem_resp -> lsu_done with lsu_err=1 at mem_req+5. A late mem_resp is ignored.
